// File: rtl/reg_write_decoder.sv
// Registered one-hot write-enable decoder for a register file, with a
// clear-sweep mode that walks every register index once and then pulses done.
module reg_write_decoder #(
    parameter int unsigned ADDR_W    = 5,
    parameter bit          MASK_ZERO = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ctrl_writeEnable,
    input  logic [ADDR_W-1:0]        ctrl_writeReg,
    input  logic                     sweep_start,
    output logic [(1<<ADDR_W)-1:0]   one_hot,
    output logic                     sweep_busy,
    output logic                     sweep_done,
    output logic                     write_dropped
);

    localparam int unsigned N  = 1 << ADDR_W;
    localparam int unsigned CW = ADDR_W + 1;
    localparam int unsigned F  = MASK_ZERO ? 32'd1 : 32'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    one_hot_q, one_hot_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            drop_q, drop_d;
    logic            masked_c;

    // Index 0 is reserved (e.g. a hard-wired zero register) when masking is on.
    assign masked_c = MASK_ZERO && (ctrl_writeReg == '0);

    // Next-state and next-output logic; every output register defaults low.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        one_hot_d = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        drop_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d   = SWEEP;
                    one_hot_d = N'(1) << F;
                    cnt_d     = CW'(F + 1);
                    busy_d    = 1'b1;
                    drop_d    = ctrl_writeEnable;
                end else if (ctrl_writeEnable && !masked_c) begin
                    one_hot_d = N'(1) << ctrl_writeReg;
                end
            end
            SWEEP: begin
                drop_d = ctrl_writeEnable;
                // Counter runs one ahead of the displayed index; N means N-1 was shown.
                if (cnt_q == CW'(N)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    one_hot_d = N'(1) << cnt_q[ADDR_W-1:0];
                    busy_d    = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                drop_d  = ctrl_writeEnable;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            one_hot_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            one_hot_q <= one_hot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
        end
    end

    assign one_hot       = one_hot_q;
    assign sweep_busy    = busy_q;
    assign sweep_done    = done_q;
    assign write_dropped = drop_q;

endmodule
